mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//   Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers for the single-cycle MIPS core.
//   Sits downstream of pc_memprog_regfile: consumes RD1 (rs), RD2 (rt) and Instr[5:0] (funct).
//   Exposes HI/LO for MFHI/MFLO, and busy for the control unit to stall PC/regfile writes.
// PARAMETERS
//   WIDTH   32   operand width; HI/LO each WIDTH bits; iteration count = WIDTH
// PORTS
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous, active-high; clears all state
//   start    in   1      issue request; sampled only in IDLE
//   funct    in   6      Instr[5:0]: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO
//   RD1      in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
//   RD2      in   WIDTH  rt operand (multiplier / divisor)
//   cancel   in   1      synchronous abort of an in-flight op; HI/LO keep their old values
//   busy     out  1      high while an op is in CALC or FIX; core must stall MFHI/MFLO/new muldiv
//   done     out  1      one-cycle pulse when HI/LO are updated by a MULT*/DIV*
//   dz       out  1      sticky flag from the last DIV/DIVU: divisor was zero; cleared at next start
//   hi       out  WIDTH  HI register (remainder / upper product)
//   lo       out  WIDTH  LO register (quotient / lower product)
// BEHAVIOUR
//   Reset (async): state=IDLE; hi=lo=0; busy=done=dz=0; iteration counter=0. Mid-operation reset aborts.
//   FSM: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: start & MULT*/DIV* funct -> latch operands and the op at edge N; go to CALC; busy=1 from edge N.
//     Signed ops latch |RD1| and |RD2| plus the sign bits; unsigned ops latch raw values.
//     start & MTHI -> hi<=RD1 at edge N; MTLO -> lo<=RD1; no busy, no done, stay IDLE.
//     start with any other funct -> ignored.
//   CALC: exactly WIDTH cycles, one bit per cycle.
//     Multiply: shift-add, 2*WIDTH-bit accumulator.
//     Divide: restoring, WIDTH+1-bit partial remainder.
//   FIX: one cycle. Apply the sign correction and write hi/lo at edge N+WIDTH+1.
//     done=1 for the following cycle; busy=0 after that edge.
//     Total latency: start edge to result edge = WIDTH+1 clocks (33 at default).
//   Signed rules:
//     MULT: {hi,lo} = two's-complement 64-bit product.
//     DIV: quotient negative iff operand signs differ; remainder takes the dividend's sign (truncating division).
//     Overflow case 0x80000000 / -1: lo=0x80000000, hi=0.
//   Divide by zero (DIV or DIVU): still takes full latency; lo=0xFFFFFFFF, hi=RD1 as latched, dz=1.
//   start while busy: ignored; the upstream stall holds the instruction until busy falls.
//   cancel in CALC/FIX: -> IDLE next edge; hi/lo unchanged; no done pulse. cancel in IDLE: no effect.
//   cancel and reset together: reset wins.
//   hi/lo change only at the FIX edge, on MTHI/MTLO, or on reset.
// TESTING
//   1. reset high 20ns, then low -> hi=lo=0, busy=0; MFHI path reads 0.
//   2. MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 clks hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
//   3. MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   4. DIVU 100/0 -> lo=0xFFFFFFFF, hi=100, dz=1; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//   5. cancel at CALC cycle 10 of DIVU 50/7 -> busy drops next edge, hi/lo keep prior values, no done.
//      Then MTLO 0x1234 -> lo=0x1234 in 1 clk.
//   6. reset pulse mid-MULT (cycle 5) -> immediate busy=0, hi=lo=0.
//      A second start during busy is ignored; result matches the first op only.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fix at the end.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, nstate;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opa, opb, rem;
  logic [2*WIDTH-1:0] acc;
  logic               op_div, op_sgn;
  logic               neg_a, neg_b, bzero;

  logic               is_mul, is_div, sgn, go;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, rem_sh, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;

  assign is_mul = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div = (funct == F_DIV) || (funct == F_DIVU);
  assign sgn    = (funct == F_MULT) || (funct == F_DIV);
  assign go     = start && (state == IDLE) && (is_mul || is_div);
  assign mag_a  = (sgn && RD1[WIDTH-1]) ? -RD1 : RD1;
  assign mag_b  = (sgn && RD2[WIDTH-1]) ? -RD2 : RD2;
  assign busy   = (state != IDLE);

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) mul_sum = mul_sum + {1'b0, opa};
    rem_sh = {rem, acc[WIDTH-1]};
    trial  = rem_sh - {1'b0, opb};
  end

  // Magnitude results back to two's complement; divide-by-zero
  // leaves the dividend as remainder and forces an all-ones quotient.
  always_comb begin
    prod = acc;
    quo  = acc[WIDTH-1:0];
    rmd  = rem;
    if (op_sgn && (neg_a ^ neg_b)) begin
      prod = -acc;
      quo  = -acc[WIDTH-1:0];
    end
    if (op_sgn && neg_a) rmd = -rem;
    if (bzero) quo = '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (go) nstate = CALC;
      CALC: begin
        if (cancel)                       nstate = IDLE;
        else if (cnt == CW'(WIDTH - 1))   nstate = FIX;
      end
      FIX:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      dz     <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      opa    <= '0;
      opb    <= '0;
      op_div <= 1'b0;
      op_sgn <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      bzero  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            opa    <= mag_a;
            opb    <= mag_b;
            op_div <= is_div;
            op_sgn <= sgn;
            neg_a  <= sgn && RD1[WIDTH-1];
            neg_b  <= sgn && RD2[WIDTH-1];
            bzero  <= is_div && (RD2 == '0);
            acc    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            rem    <= '0;
            cnt    <= '0;
            dz     <= 1'b0;
          end else if (start && (funct == F_MTHI)) begin
            hi <= RD1;
          end else if (start && (funct == F_MTLO)) begin
            lo <= RD1;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (op_div) begin
            rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~trial[WIDTH]};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!cancel) begin
            done <= 1'b1;
            if (op_div) begin
              hi <= rmd;
              lo <= quo;
              dz <= bzero;
            end else begin
              {hi, lo} <= prod;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Random and directed bench for mips_muldiv_unit against an
// arithmetic reference model with per-cycle output comparison.
module tb_mips_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] RD1 = '0;
  logic [W-1:0] RD2 = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct (funct),
    .RD1   (RD1),
    .RD2   (RD2),
    .cancel(cancel),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
  endtask

  // Architectural result of one op: {dz, hi, lo}
  function automatic logic [2*W:0] ref_op(input logic [5:0] f,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint          sp;
    logic [2*W-1:0]  up;
    logic [W-1:0]    q, r;
    logic            z;
    logic [2*W:0]    res;
    sp = 0; up = '0; q = '0; r = '0; z = 1'b0; res = '0;
    case (f)
      6'h18: begin
        sp  = longint'($signed(a)) * longint'($signed(b));
        res = {1'b0, sp[63:0]};
      end
      6'h19: begin
        up  = {32'h0, a} * {32'h0, b};
        res = {1'b0, up};
      end
      6'h1A: begin
        if (b == '0) begin
          z = 1'b1; q = '1; r = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000; r = '0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end
        res = {z, r, q};
      end
      default: begin
        if (b == '0) begin
          z = 1'b1; q = '1; r = a;
        end else begin
          q = a / b;
          r = a % b;
        end
        res = {z, r, q};
      end
    endcase
    return res;
  endfunction

  logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] p_hi = '0, p_lo = '0;
  logic         p_dz = 1'b0;
  int           m_left = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (cancel) m_busy <= 1'b0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_busy <= 1'b0; m_done <= 1'b1;
            m_hi <= p_hi; m_lo <= p_lo; m_dz <= p_dz;
          end
        end
      end else if (start) begin
        if (funct inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
          {p_dz, p_hi, p_lo} <= ref_op(funct, RD1, RD2);
          m_busy <= 1'b1;
          m_left <= W + 1;
          m_dz   <= 1'b0;
        end else if (funct == 6'h11) m_hi <= RD1;
        else if (funct == 6'h13) m_lo <= RD1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("dz", dz, m_dz);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    if (done) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    start = 1'b1; funct = f; RD1 = a; RD2 = b;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int bc);
    bc = 0;
    while (busy && bc < 60) begin
      bc++;
      step();
    end
    check("idle_bound", busy, 1'b0);
  endtask

  function automatic logic [W-1:0] rv();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = W'($urandom_range(0, 15));
      4:       v = W'(0) - W'($urandom_range(1, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  logic [5:0] fl [8] = '{6'h18, 6'h19, 6'h1A, 6'h1B,
                         6'h11, 6'h13, 6'h00, 6'h2A};

  initial begin
    int bc;
    int d0;
    #1 reset = 1'b1;
    #20 reset = 1'b0;
    step();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);

    d0 = done_cnt;
    issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(bc);
    check("multu_lat", bc, 33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    step();
    check("multu_done_once", done_cnt - d0, 1);

    issue(6'h18, 32'hFFFF_FFF9, 32'd3);
    wait_idle(bc);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    issue(6'h1A, 32'hFFFF_FFF9, 32'd2);
    wait_idle(bc);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(6'h1B, 32'd100, 32'd0);
    wait_idle(bc);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'd100);
    check("divz_dz", dz, 1);

    issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(bc);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 0);
    check("ovf_dz", dz, 0);

    d0 = done_cnt;
    issue(6'h1B, 32'd50, 32'd7);
    repeat (9) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_hi", hi, 0);
    check("cancel_lo", lo, 32'h8000_0000);
    step();
    check("cancel_nodone", done_cnt - d0, 0);

    issue(6'h13, 32'h0000_1234, 32'd0);
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_busy", busy, 0);
    issue(6'h11, 32'hDEAD_BEEF, 32'd0);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    issue(6'h2A, 32'd5, 32'd5);
    check("bad_funct_busy", busy, 0);

    issue(6'h18, 32'd5, 32'd5);
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    #2 reset = 1'b0;
    step();

    issue(6'h18, 32'd6, 32'd7);
    repeat (3) step();
    issue(6'h19, 32'd9, 32'd9);
    wait_idle(bc);
    check("ign_lo", lo, 32'd42);
    check("ign_hi", hi, 0);
    step();
    check("ign_busy", busy, 0);

    repeat (2500) begin
      step();
      start  = ($urandom_range(0, 2) == 0);
      funct  = fl[$urandom_range(0, 7)];
      RD1    = rv();
      RD2    = rv();
      cancel = ($urandom_range(0, 63) == 0);
    end
    step();
    start = 1'b0;
    cancel = 1'b0;
    wait_idle(bc);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end
endmodule
